// File: rtl/fwd_hazard_if.sv
// -----------------------------------------------------------------------------
// fwd_hazard_if
//   Bundle of the pipeline-side signals seen by the ID/EX operand bypass and
//   load-use hazard unit.
//
//   Parameters
//     len      data word width
//     nb_addr  register address width
//     n_ports  number of EX operand ports (port k uses slice [k*W +: W])
//     nb_cnt   stall counter width
//
//   Signals (direction as seen by the hazard unit, i.e. the slave modport)
//     i_pipe_en        in   pipeline advance, 0 freezes internal state
//     i_ex_src_addr    in   EX source register addresses, one per port
//     i_ex_src_data    in   register-file values latched in ID/EX
//     i_mem_rd         in   EX/MEM destination register
//     i_mem_regwrite   in   EX/MEM write flag
//     i_mem_data       in   EX/MEM ALU result
//     i_wb_rd          in   MEM/WB destination register
//     i_wb_regwrite    in   MEM/WB write flag
//     i_wb_data        in   MEM/WB final writeback value
//     i_id_src_addr    in   ID source register addresses, one per port
//     i_ex_rd          in   destination of the instruction in EX
//     i_ex_memread     in   instruction in EX is a load
//     o_operand        out  forwarded operands, one per port
//     o_select         out  per-port source code: 00 reg, 01 mem, 10 wb, 11 history
//     o_stall          out  freeze PC/IF-ID and bubble ID/EX
//     o_stall_count    out  saturating count of stall cycles
//
//   Modports
//     master  pipeline side (drives the i_* signals, observes the o_* signals)
//     slave   hazard unit side
// -----------------------------------------------------------------------------
interface fwd_hazard_if #(
  parameter int len     = 32,
  parameter int nb_addr = 5,
  parameter int n_ports = 2,
  parameter int nb_cnt  = 16
);

  logic                         i_pipe_en;
  logic [n_ports*nb_addr-1:0]   i_ex_src_addr;
  logic [n_ports*len-1:0]       i_ex_src_data;
  logic [nb_addr-1:0]           i_mem_rd;
  logic                         i_mem_regwrite;
  logic [len-1:0]               i_mem_data;
  logic [nb_addr-1:0]           i_wb_rd;
  logic                         i_wb_regwrite;
  logic [len-1:0]               i_wb_data;
  logic [n_ports*nb_addr-1:0]   i_id_src_addr;
  logic [nb_addr-1:0]           i_ex_rd;
  logic                         i_ex_memread;

  logic [n_ports*len-1:0]       o_operand;
  logic [n_ports*2-1:0]         o_select;
  logic                         o_stall;
  logic [nb_cnt-1:0]            o_stall_count;

  modport master (
    output i_pipe_en, i_ex_src_addr, i_ex_src_data,
           i_mem_rd, i_mem_regwrite, i_mem_data,
           i_wb_rd, i_wb_regwrite, i_wb_data,
           i_id_src_addr, i_ex_rd, i_ex_memread,
    input  o_operand, o_select, o_stall, o_stall_count
  );

  modport slave (
    input  i_pipe_en, i_ex_src_addr, i_ex_src_data,
           i_mem_rd, i_mem_regwrite, i_mem_data,
           i_wb_rd, i_wb_regwrite, i_wb_data,
           i_id_src_addr, i_ex_rd, i_ex_memread,
    output o_operand, o_select, o_stall, o_stall_count
  );

endinterface

// File: rtl/fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit
//   Operand bypass and load-use hazard unit for a 5-stage MIPS pipeline,
//   placed at the ID/EX boundary.
//
//   - Per EX operand port, picks the operand among the register file value,
//     the EX/MEM result, the MEM/WB result and (optionally) a one-entry
//     history of the last writeback. Priority: r0 -> reg, mem, wb, history.
//   - Detects a load in EX whose destination is read by the instruction in ID
//     and raises a single-cycle stall through a two-state FSM.
//   - Counts stall cycles in a saturating counter for the debug unit.
//
//   Ports
//     clk    pipeline clock, all state updates on the rising edge
//     reset  synchronous, active-high
//     bus    fwd_hazard_if.slave, see rtl/fwd_hazard_if.sv
//
//   Configuration macro
//     FWD_HISTORY_EN  when defined, the write-history register exists and
//                     select code 11 can be produced. Needed when the
//                     register file writes on the rising edge after a read.
//                     When undefined (default) the register file is assumed
//                     write-before-read and history matches fall to 00.
//
//   FSM
//     state   | meaning
//     --------+---------------------------------------------------------
//     S_RUN   | normal flow, o_stall follows the load-use hit
//     S_STALL | bubble already inserted for this load, no further stall
// -----------------------------------------------------------------------------
module fwd_hazard_unit #(
  parameter int len     = 32,
  parameter int nb_addr = 5,
  parameter int n_ports = 2,
  parameter int nb_cnt  = 16
) (
  input  logic          clk,
  input  logic          reset,
  fwd_hazard_if.slave   bus
);

  localparam logic [1:0] SEL_REG  = 2'b00;
  localparam logic [1:0] SEL_MEM  = 2'b01;
  localparam logic [1:0] SEL_WB   = 2'b10;
  localparam logic [1:0] SEL_HIST = 2'b11;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_STALL = 1'b1
  } state_t;

  state_t                  state_q;
  logic [nb_cnt-1:0]       stall_cnt_q;
  logic [nb_cnt-1:0]       stall_cnt_d;
  logic                    hit;
  logic                    stall;
  logic [n_ports*2-1:0]    sel_all;
  logic [n_ports*len-1:0]  operand_all;

  // ---------------------------------------------------------------------------
  // Write-history register: remembers the instruction that left WB on the
  // previous advance. While reset is held the entry is treated as invalid so
  // forwarding during reset never uses a stale history value.
  // ---------------------------------------------------------------------------
`ifdef FWD_HISTORY_EN
  logic               hist_valid_q;
  logic [nb_addr-1:0] hist_rd_q;
  logic [len-1:0]     hist_data_q;
  logic               hist_valid;

  assign hist_valid = hist_valid_q & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_valid_q <= 1'b0;
      hist_rd_q    <= '0;
      hist_data_q  <= '0;
    end else if (bus.i_pipe_en) begin
      if (bus.i_wb_regwrite && (bus.i_wb_rd != '0)) begin
        hist_valid_q <= 1'b1;
        hist_rd_q    <= bus.i_wb_rd;
        hist_data_q  <= bus.i_wb_data;
      end else begin
        hist_valid_q <= 1'b0;
      end
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Per-port operand selection, fully combinational.
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < n_ports; k++) begin : g_port
    logic [nb_addr-1:0] src;
    logic [len-1:0]     reg_val;
    logic               mem_hit;
    logic               wb_hit;
    logic               hist_hit;
    logic [1:0]         sel;
    logic [len-1:0]     operand;

    assign src     = bus.i_ex_src_addr[k*nb_addr +: nb_addr];
    assign reg_val = bus.i_ex_src_data[k*len +: len];
    assign mem_hit = bus.i_mem_regwrite && (bus.i_mem_rd == src);
    assign wb_hit  = bus.i_wb_regwrite  && (bus.i_wb_rd  == src);
`ifdef FWD_HISTORY_EN
    assign hist_hit = hist_valid && (hist_rd_q == src);
`else
    assign hist_hit = 1'b0;
`endif

    // r0 is hardwired to zero, so it is never forwarded even if some stage
    // claims to write it.
    always_comb begin
      sel = SEL_REG;
      if (src == '0) begin
        sel = SEL_REG;
      end else if (mem_hit) begin
        sel = SEL_MEM;
      end else if (wb_hit) begin
        sel = SEL_WB;
      end else if (hist_hit) begin
        sel = SEL_HIST;
      end
    end

    always_comb begin
      operand = reg_val;
      case (sel)
        SEL_MEM:  operand = bus.i_mem_data;
        SEL_WB:   operand = bus.i_wb_data;
`ifdef FWD_HISTORY_EN
        SEL_HIST: operand = hist_data_q;
`endif
        default:  operand = reg_val;
      endcase
    end

    assign sel_all[k*2 +: 2]       = sel;
    assign operand_all[k*len +: len] = operand;
  end

  assign bus.o_select  = sel_all;
  assign bus.o_operand = operand_all;

  // ---------------------------------------------------------------------------
  // Load-use detection: a load in EX whose destination is read in ID.
  // ---------------------------------------------------------------------------
  always_comb begin
    hit = 1'b0;
    if (bus.i_ex_memread && (bus.i_ex_rd != '0)) begin
      for (int k = 0; k < n_ports; k++) begin
        if (bus.i_id_src_addr[k*nb_addr +: nb_addr] == bus.i_ex_rd) begin
          hit = 1'b1;
        end
      end
    end
  end

  // Once the bubble is in, the producer reaches MEM and the consumer is
  // served by mem/wb forwarding, so at most one stall cycle per load.
  assign stall     = ~reset && (state_q == S_RUN) && hit;
  assign bus.o_stall = stall;

  // ---------------------------------------------------------------------------
  // RUN/STALL sequencer.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RUN;
    end else if (bus.i_pipe_en) begin
      case (state_q)
        S_RUN:   state_q <= hit ? S_STALL : S_RUN;
        S_STALL: state_q <= S_RUN;
        default: state_q <= S_RUN;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating stall counter.
  // ---------------------------------------------------------------------------
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bus.i_pipe_en && stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.o_stall_count = stall_cnt_q;

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised operand-bypass and load-use hazard unit for the 5-stage MIPS pipeline, sitting at the ID/EX boundary. It selects each EX-stage source operand among the register-file value, the EX/MEM result, the MEM/WB result and a one-entry write-history register, for `n_ports` operand ports. It also detects load-use hazards from the ID stage, issues a single-cycle stall through a two-state FSM, and keeps a saturating stall counter for the debug unit.

## Interface
Parameters:
- `len`, 32, data word width.
- `nb_addr`, 5, register address width.
- `n_ports`, 2, number of EX operand ports (≥1).
- `nb_cnt`, 16, stall counter width.

Ports (port k occupies slice `[k*W +: W]` of every packed bus):
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `i_pipe_en`  in  1  pipeline advance; 0 freezes all internal state.
- `i_ex_src_addr`  in  n_ports*nb_addr  source register addresses of the instruction in EX.
- `i_ex_src_data`  in  n_ports*len  register-file values latched in ID/EX.
- `i_mem_rd`, `i_mem_regwrite`, `i_mem_data`  in  nb_addr/1/len  EX/MEM destination, write flag, ALU result.
- `i_wb_rd`, `i_wb_regwrite`, `i_wb_data`  in  nb_addr/1/len  MEM/WB destination, write flag, final writeback value.
- `i_id_src_addr`  in  n_ports*nb_addr  source addresses of the instruction in ID.
- `i_ex_rd`, `i_ex_memread`  in  nb_addr/1  destination and load flag of the instruction in EX.
- `o_operand`  out  n_ports*len  forwarded operands.
- `o_select`  out  n_ports*2  per port: 00 reg, 01 mem, 10 wb, 11 history.
- `o_stall`  out  1  freeze PC/IF-ID and insert a bubble in ID/EX.
- `o_stall_count`  out  nb_cnt  saturating count of stall cycles.

## Operation
- Operand select, per port, independently and combinationally, with fixed priority:
  - Source address 0 → always 00 (reg).
  - Else `i_mem_regwrite` and `i_mem_rd` match → 01.
  - Else `i_wb_regwrite` and `i_wb_rd` match → 10.
  - Else history valid and history rd match → 11.
  - Else 00.
- `o_operand` is the value of the selected source.
- History register (rd, data, valid):
  - Loaded when `i_pipe_en` and `i_wb_regwrite` and `i_wb_rd` ≠ 0.
  - When `i_pipe_en` is 1 without a qualifying write, valid clears.
  - It therefore covers only the instruction that left WB on the previous advance.
- FSM states RUN and STALL:
  - hit = `i_ex_memread`, `i_ex_rd` ≠ 0, and `i_ex_rd` equals any `i_id_src_addr` port.
  - RUN: `o_stall` = hit. On an edge with `i_pipe_en` and hit → STALL.
  - STALL: `o_stall` = 0. On an edge with `i_pipe_en` → RUN.
  - Max stall length is one cycle per load; the bubble makes the dependency distance 2, which is then resolved through the mem/wb forwarding paths.
- `i_pipe_en` = 0: state, history and counter hold; the combinational outputs still track the inputs.
- Stall counter increments on an edge where `o_stall` and `i_pipe_en` are both 1; it saturates at all ones.

## Timing
- `o_operand`, `o_select`: zero latency, combinational.
- `o_stall`: combinational from state and inputs; it is forced to 0 while `reset` = 1.
- Reset values: FSM RUN, history valid 0, rd 0, data 0, `o_stall_count` 0. During reset, `o_select` and `o_operand` follow the forwarding rules with history invalid.
- Reset asserted in STALL → next state RUN; no stall is counted on that edge.
- Simultaneous mem and wb match on the same register → mem wins (youngest producer).
- Mem and history match the same register → mem wins. Wb and history match → wb wins.

## Configuration
- `FWD_HISTORY_EN` defined:
  - History register is present and select code 11 is used.
  - Required for register files that write on the rising edge after a read.
- `FWD_HISTORY_EN` not defined:
  - No history flops.
  - Code 11 is never produced; matches that would have hit history fall through to 00.
  - The unit is intended for register files with write-before-read (negedge write).

## Test plan
- Port 0 addr 3, `i_mem_rd` = 3 with regwrite, `i_wb_rd` = 3 with regwrite, mem = 0xAAAA0000, wb = 0x5555 → select 01, operand 0xAAAA0000.
- Port 1 addr 0, mem and wb both target r0 with regwrite → select 00, operand = `i_ex_src_data` port 1.
- WB writes r7 = 0x1234 with `i_pipe_en`; next cycle no WB write, port 0 addr 7 → select 11, operand 0x1234 (macro on). With the macro off → select 00.
- `i_ex_memread` = 1, `i_ex_rd` = 4, ID port 1 addr 4 → `o_stall` = 1 for exactly one cycle. Hold hit for 3 cycles → stall pattern 1,0,1; counter reaches 2.
- `i_pipe_en` = 0 with hit in RUN → `o_stall` = 1 every cycle; state and counter unchanged. Reset asserted in STALL → RUN, counter 0, `o_stall` = 0 during reset.
- Force counter to 2^nb_cnt−1 via repeated load-use → it stays at all ones on further stalls.
